// File: rtl/arith_ctrl.sv
// arith_ctrl: multi-cycle arithmetic controller.
// Add/sub finish in two cycles. Multiply uses an iterative shift-add and
// divide uses an iterative restoring division; each takes WIDTH cycles.
// Optional feature macro: ARITH_CTRL_DIV_EN builds the divide datapath.
// When that macro is undefined, op=11 completes at once with err=1 and result=0.
module arith_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   A_in,
    input  logic [WIDTH-1:0]   B_in,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic               OVR,
    output logic               err
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDSUB = 2'd1,
        ITER   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   hi_q, hi_d;    // mul: product high half / div: partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;    // mul: multiplier, then product low half / div: dividend, then quotient
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ovr_q, ovr_d;
    logic               err_q, err_d;

    // Add/sub datapath: subtraction is A + ~B + 1.
    logic               as_sub;
    logic [WIDTH-1:0]   as_b;
    logic [WIDTH:0]     as_sum;
    logic               as_cin_msb;
    logic               as_ovr;

    // One iteration of the multiply/divide datapath.
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   it_hi;
    logic [WIDTH-1:0]   it_lo;

    // Add/sub result, and overflow from the carries into and out of the MSB.
    always_comb begin
        as_sub     = (op_q == OP_SUB);
        as_b       = as_sub ? ~b_q : b_q;
        as_sum     = {1'b0, a_q} + {1'b0, as_b} + {{WIDTH{1'b0}}, as_sub};
        // A sum bit is a ^ b ^ carry_in, so the carry into the MSB can be recovered from it.
        as_cin_msb = as_sum[WIDTH-1] ^ a_q[WIDTH-1] ^ as_b[WIDTH-1];
        as_ovr     = as_cin_msb ^ as_sum[WIDTH];
    end

`ifdef ARITH_CTRL_DIV_EN
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic               div_fit;

    // Shift-add multiply step and restoring divide step; op_q selects which one is used.
    always_comb begin
        mul_addend = lo_q[0] ? a_q : '0;
        mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
        // Trial subtraction of the low WIDTH bits. The partial remainder fits
        // when the shifted-out bit is set or the subtraction does not borrow.
        div_shift  = {hi_q, lo_q[WIDTH-1]};
        div_trial  = {1'b0, div_shift[WIDTH-1:0]} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        div_fit    = div_shift[WIDTH] | div_trial[WIDTH];
        if (op_q == OP_MUL) begin
            it_hi = mul_sum[WIDTH:1];
            it_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            it_hi = div_fit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            it_lo = {lo_q[WIDTH-2:0], div_fit};
        end
    end
`else
    // Shift-add multiply step: add the multiplicand when the multiplier LSB is 1, then shift right.
    always_comb begin
        mul_addend = lo_q[0] ? a_q : '0;
        mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
        it_hi      = mul_sum[WIDTH:1];
        it_lo      = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
`endif

    // Next-state logic: operand capture, sequencing, and result load on entry to DONE.
    always_comb begin
        // NOTE: every signal gets a hold value first, so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovr_d    = ovr_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    a_d   = A_in;
                    b_d   = B_in;
                    hi_d  = '0;
                    cnt_d = CW'(WIDTH - 1);
                    case (op)
                        OP_ADD, OP_SUB: state_d = ADDSUB;
                        OP_MUL: begin
                            lo_d    = B_in;
                            state_d = ITER;
                        end
                        default: begin
`ifdef ARITH_CTRL_DIV_EN
                            if (B_in == '0) begin
                                result_d = {A_in, {WIDTH{1'b1}}};
                                ovr_d    = 1'b0;
                                err_d    = 1'b1;
                                state_d  = DONE;
                            end else begin
                                lo_d    = A_in;
                                state_d = ITER;
                            end
`else
                            result_d = '0;
                            ovr_d    = 1'b0;
                            err_d    = 1'b1;
                            state_d  = DONE;
`endif
                        end
                    endcase
                end
            end
            ADDSUB: begin
                result_d = {{(WIDTH-1){1'b0}}, as_sum};
                ovr_d    = as_ovr;
                err_d    = 1'b0;
                state_d  = DONE;
            end
            ITER: begin
                hi_d = it_hi;
                lo_d = it_lo;
                if (cnt_q == '0) begin
                    result_d = {it_hi, it_lo};
                    ovr_d    = 1'b0;
                    err_d    = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovr_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovr_q    <= ovr_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q == ADDSUB) || (state_q == ITER);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign OVR    = ovr_q;
    assign err    = err_q;

endmodule

// File: tb/tb_arith_ctrl.sv
// Testbench for arith_ctrl with WIDTH=8.
// Directed cases cover the documented corner cases, followed by random operations.
// Each operation is checked against an arithmetic reference model for result,
// flags, done latency, and the busy waveform.
module tb_arith_ctrl;

    localparam int W     = 8;
    localparam int LIMIT = 2 * W + 6;

    logic           clk;
    logic           rst;
    logic           start;
    logic [1:0]     op;
    logic [W-1:0]   A_in;
    logic [W-1:0]   B_in;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           OVR;
    logic           err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2*W-1:0] result;
        logic           ovr;
        logic           err;
        int             lat;
    } exp_t;

    arith_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .A_in   (A_in),
        .B_in   (B_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .OVR    (OVR),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's definition.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int ua = int'(a);
        int ub = int'(b);
        int sa = int'($signed(a));
        int sb = int'($signed(b));
        int s;
        e.result = '0;
        e.ovr    = 1'b0;
        e.err    = 1'b0;
        e.lat    = 2;
        case (o)
            2'b00: begin
                e.result = 16'(ua + ub);
                s        = sa + sb;
                e.ovr    = (s > 127) || (s < -128);
            end
            2'b01: begin
                e.result = {7'd0, (ua >= ub), 8'(ua - ub)};
                s        = sa - sb;
                e.ovr    = (s > 127) || (s < -128);
            end
            2'b10: begin
                e.result = 16'(ua * ub);
                e.lat    = W + 1;
            end
            default: begin
`ifdef ARITH_CTRL_DIV_EN
                if (ub == 0) begin
                    e.result = {a, 8'hFF};
                    e.err    = 1'b1;
                    e.lat    = 1;
                end else begin
                    e.result = {8'(ua % ub), 8'(ua / ub)};
                    e.lat    = W + 1;
                end
`else
                e.result = '0;
                e.err    = 1'b1;
                e.lat    = 1;
`endif
            end
        endcase
        return e;
    endfunction

    // Issue one request at a negedge and follow it cycle by cycle until done.
    // If hold is set, start stays high (with changing operands) until the done cycle.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        exp_t e;
        int got;
        int k;
        e     = model(o, a, b);
        got   = 0;
        start = 1'b1;
        op    = o;
        A_in  = a;
        B_in  = b;
        @(negedge clk);
        if (!hold) start = 1'b0;
        // Operands change after the accepting edge and must not affect the result.
        op   = 2'($urandom);
        A_in = 8'($urandom);
        B_in = 8'($urandom);
        k = 1;
        while (k <= LIMIT && got == 0) begin
            check($sformatf("busy op=%0d k=%0d", o, k), 32'(busy), 32'(k < e.lat));
            if (done) begin
                got   = k;
                start = 1'b0;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check($sformatf("latency op=%0d a=%h b=%h", o, a, b), 32'(got), 32'(e.lat));
        check($sformatf("result op=%0d a=%h b=%h", o, a, b), 32'(result), 32'(e.result));
        check($sformatf("OVR op=%0d a=%h b=%h", o, a, b), 32'(OVR), 32'(e.ovr));
        check($sformatf("err op=%0d a=%h b=%h", o, a, b), 32'(err), 32'(e.err));
        @(negedge clk);
        check("done one-cycle", 32'(done), 32'd0);
        check("result held", 32'(result), 32'(e.result));
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           pulses;

        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        A_in  = '0;
        B_in  = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset OVR", 32'(OVR), 32'd0);
        check("reset err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Documented directed cases.
        do_op(2'b00, 8'h7F, 8'h01, 1'b0);
        do_op(2'b01, 8'h05, 8'h0A, 1'b0);
        do_op(2'b10, 8'hFF, 8'hFF, 1'b0);
        do_op(2'b11, 8'd200, 8'd7, 1'b0);
        do_op(2'b11, 8'd200, 8'd0, 1'b0);
        do_op(2'b01, 8'h80, 8'h01, 1'b0);
        do_op(2'b01, 8'h33, 8'h00, 1'b0);
        do_op(2'b00, 8'hFF, 8'hFF, 1'b0);

        // start held high through a multiply, then a normal request afterwards.
        do_op(2'b10, 8'h12, 8'h34, 1'b1);
        pulses = 0;
        repeat (4) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check("held start extra pulses", 32'(pulses), 32'd0);
        do_op(2'b00, 8'h10, 8'h20, 1'b0);

        // Reset in cycle 4 of a multiply.
        start = 1'b1;
        op    = 2'b10;
        A_in  = 8'hAB;
        B_in  = 8'hCD;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset done", 32'(done), 32'd0);
        check("midreset result", 32'(result), 32'd0);
        check("midreset OVR", 32'(OVR), 32'd0);
        check("midreset err", 32'(err), 32'd0);
        pulses = 0;
        repeat (12) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        check("midreset no done/busy", 32'(pulses), 32'd0);
        do_op(2'b10, 8'hAB, 8'hCD, 1'b0);

        // Reset and start asserted on the same edge: the request is not accepted.
        rst   = 1'b1;
        start = 1'b1;
        op    = 2'b10;
        A_in  = 8'h05;
        B_in  = 8'h06;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst-priority busy", 32'(busy), 32'd0);
        check("rst-priority result", 32'(result), 32'd0);
        pulses = 0;
        repeat (12) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        check("rst-priority no activity", 32'(pulses), 32'd0);

        // Random operations.
        repeat (40) begin
            ro = 2'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            do_op(ro, ra, rb, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arith_ctrl.md
ARITH_CTRL -- requirements
Module: arith_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-006 SHALL have ports A_in and B_in  input  WIDTH each  operands, sampled on the accepting edge only.
REQ-007 SHALL have port busy  output  1  high while an operation is executing.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port result  output  2*WIDTH  operation result.
REQ-010 SHALL have port OVR  output  1  signed overflow flag for add/sub.
REQ-011 SHALL have port err  output  1  divide-by-zero or unsupported operation.

Function
REQ-012 SHALL implement FSM states IDLE, ADDSUB, ITER, DONE.
REQ-013 SHALL accept a request when start=1 in IDLE and latch op, A_in and B_in on that edge, the accepting edge.
REQ-014 SHALL ignore start in every state other than IDLE, with no queuing.
REQ-015 SHALL hold busy=1 in ADDSUB and ITER, and busy=0 in IDLE and DONE.
REQ-016 SHALL assert done=1 only in DONE, for exactly one cycle, then return to IDLE.
REQ-017 SHALL handle add and sub as follows:
- IDLE->ADDSUB->DONE; done high 2 cycles after the accepting edge.
- Add: result = {0..., cout, A+B}.
- Sub: A+~B+1, with result[WIDTH] = carry out (1 = no borrow).
- OVR = carry into MSB XOR carry out of MSB.
REQ-018 SHALL handle mul as follows:
- Unsigned shift-add in ITER using one WIDTH-bit adder.
- WIDTH iterations, each consuming one multiplier LSB.
- done high WIDTH+1 cycles after the accepting edge.
- result = full 2*WIDTH-bit product.
REQ-019 SHALL handle div as follows:
- Unsigned restoring division in ITER, WIDTH iterations, using one trial subtraction per cycle.
- result[2*WIDTH-1:WIDTH] = remainder; result[WIDTH-1:0] = quotient.
- done high WIDTH+1 cycles after the accepting edge.
REQ-020 SHALL treat div with B_in=0 as follows:
- IDLE->DONE directly; done high 1 cycle after the accepting edge.
- err=1; result = {A_in, all-ones quotient}.
REQ-021 SHALL force OVR=0 for mul and div.
REQ-022 SHALL use an iteration counter running WIDTH-1 down to 0; ITER exits to DONE on the edge where the count is 0.
REQ-023 SHALL update result, OVR and err only on entry to DONE, and hold them until the next entry to DONE.
REQ-024 SHALL accept a start asserted in the cycle done=1 only once the FSM is in IDLE, i.e. on the following edge.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, go to IDLE and clear busy, done, result, OVR, err and the counter to 0, including mid-operation.
REQ-026 SHALL give rst priority over start on the same edge; no request is accepted.
REQ-027 SHALL produce no done pulse for an operation aborted by reset.

Configuration
REQ-028 SHALL honour macro ARITH_CTRL_DIV_EN:
- Defined: op=11 performs division per REQ-019 and REQ-020.
- Undefined: no divide datapath is built; op=11 goes IDLE->DONE with done 1 cycle after the accepting edge, err=1, result=0.

Verification
REQ-029 SHALL cover add: op=00, A=0x7F, B=0x01 -> done at +2, result=0x0080, OVR=1, err=0.
REQ-030 SHALL cover sub: op=01, A=0x05, B=0x0A -> done at +2, result=0x00FB, OVR=0.
REQ-031 SHALL cover mul: op=10, A=0xFF, B=0xFF -> busy for 8 cycles, done at +9, result=0xFE01.
REQ-032 SHALL cover div: op=11, A=200, B=7 -> done at +9, result=0x041C. With B=0 -> done at +1, err=1, result=0xC8FF. With the macro undefined -> done at +1, err=1, result=0.
REQ-033 SHALL cover start ignored while busy: start held high during a mul -> exactly one done pulse; a second start after done is accepted normally.
REQ-034 SHALL cover reset mid-operation: rst at cycle 4 of a mul -> all outputs 0 next cycle, no done pulse, and the next request completes correctly.
